// File: rtl/lr_sc_reservation_station_if.sv
// Issue-slot bundle between the control unit and the LR/SC reservation station.
// The master (control unit side) drives the decoded strobes, hart ID and address.
// The slave (reservation station) returns the registered SC verdict and the
// live reservation bits.
interface lr_sc_reservation_station_if #(
  parameter int NUM_THREADS = 16,
  parameter int ADDR_WIDTH  = 32
);
  localparam int TID_W = $clog2(NUM_THREADS);

  logic                   i_valid;
  logic [TID_W-1:0]       i_thread_id;
  logic [ADDR_WIDTH-1:0]  i_addr;
  logic                   i_lr;
  logic                   i_sc;
  logic                   i_store;
  logic                   o_sc_done;
  logic                   o_sc_mem_we;
  logic                   o_sc_rd_val;
  logic [NUM_THREADS-1:0] o_res_valid;

  modport master (
    output i_valid, i_thread_id, i_addr, i_lr, i_sc, i_store,
    input  o_sc_done, o_sc_mem_we, o_sc_rd_val, o_res_valid
  );

  modport slave (
    input  i_valid, i_thread_id, i_addr, i_lr, i_sc, i_store,
    output o_sc_done, o_sc_mem_we, o_sc_rd_val, o_res_valid
  );
endinterface

// File: rtl/lr_sc_reservation_station.sv
// Per-hart load-reserved / store-conditional reservation tracker for the
// barrel-threaded RV32 core. Each hart owns one reservation (valid bit plus
// granule tag). LR sets it, SC consumes it and reports a verdict one cycle
// later, and plain stores or a successful SC to the same granule kill any
// matching reservation of every hart.
module lr_sc_reservation_station #(
  parameter int NUM_THREADS = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int GRANULE_LSB = 2
) (
  input logic                        i_clk,
  input logic                        i_rst_n,
  lr_sc_reservation_station_if.slave bus
);
  localparam int TID_W = $clog2(NUM_THREADS);
  localparam int TAG_W = ADDR_WIDTH - GRANULE_LSB;

  // Reservation state: one valid bit and one granule tag per hart.
  logic [NUM_THREADS-1:0] res_v_reg;
  logic [NUM_THREADS-1:0] res_v_next;
  logic [TAG_W-1:0]       res_tag_reg [NUM_THREADS];

  // Registered SC verdict pulses.
  logic sc_done_reg;
  logic sc_mem_we_reg;
  logic sc_rd_val_reg;

  // Decoded slot, with SC > LR > store priority so illegal multi-strobe
  // slots still behave deterministically.
  logic             sc_fire;
  logic             lr_fire;
  logic             st_fire;
  logic [TAG_W-1:0] granule;
  logic [NUM_THREADS-1:0] hit;
  logic [NUM_THREADS-1:0] tag_load;
  logic             sc_success;

  assign granule = bus.i_addr[ADDR_WIDTH-1:GRANULE_LSB];
  assign sc_fire = bus.i_valid & bus.i_sc;
  assign lr_fire = bus.i_valid & ~bus.i_sc & bus.i_lr;
  assign st_fire = bus.i_valid & ~bus.i_sc & ~bus.i_lr & bus.i_store;

  // Success is judged on the state as it stood before this slot's update.
  assign sc_success = hit[bus.i_thread_id];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_hart
      localparam logic [TID_W-1:0] HART_ID = TID_W'(gi);
      logic is_issuer;

      assign is_issuer    = (bus.i_thread_id == HART_ID);
      assign hit[gi]      = res_v_reg[gi] & (res_tag_reg[gi] == granule);
      assign tag_load[gi] = lr_fire & is_issuer;

      // LR from this hart sets the reservation; its own SC always drops it;
      // a successful SC or a plain store to the same granule kills it.
      assign res_v_next[gi] =
          (lr_fire & is_issuer)              ? 1'b1 :
          (sc_fire & is_issuer)              ? 1'b0 :
          (sc_fire & sc_success & hit[gi])   ? 1'b0 :
          (st_fire & hit[gi])                ? 1'b0 :
                                               res_v_reg[gi];
    end
  endgenerate

  // Reservation registers; a reset discards every reservation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_v_reg <= '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        res_tag_reg[t] <= '0;
      end
    end else begin
      res_v_reg <= res_v_next;
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (tag_load[t]) begin
          res_tag_reg[t] <= granule;
        end
      end
    end
  end

  // SC verdict, registered so it appears exactly one cycle after the SC slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sc_done_reg   <= 1'b0;
      sc_mem_we_reg <= 1'b0;
      sc_rd_val_reg <= 1'b0;
    end else begin
      sc_done_reg   <= sc_fire;
      sc_mem_we_reg <= sc_fire & sc_success;
      sc_rd_val_reg <= sc_fire & ~sc_success;
    end
  end

  assign bus.o_sc_done   = sc_done_reg;
  assign bus.o_sc_mem_we = sc_mem_we_reg;
  assign bus.o_sc_rd_val = sc_rd_val_reg;
  assign bus.o_res_valid = res_v_reg;

endmodule

// File: tb/tb_lr_sc_reservation_station.sv
// Self-checking bench for lr_sc_reservation_station: directed scenarios from
// the LR/SC rules plus a randomized run against an array-based model.
module tb_lr_sc_reservation_station;
  localparam int NT = 16;
  localparam int AW = 32;

  logic clk;
  logic rst_n;

  lr_sc_reservation_station_if #(.NUM_THREADS(NT), .ADDR_WIDTH(AW)) bus ();

  lr_sc_reservation_station #(
    .NUM_THREADS(NT), .ADDR_WIDTH(AW), .GRANULE_LSB(2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per-hart reservation flag and granule number.
  bit          mv   [NT];
  int unsigned mtag [NT];
  bit          exp_done, exp_we, exp_rd;
  logic [NT-1:0] exp_res;

  function automatic logic [NT-1:0] model_res();
    logic [NT-1:0] r;
    for (int t = 0; t < NT; t++) r[t] = mv[t];
    return r;
  endfunction

  task automatic model_clear();
    for (int t = 0; t < NT; t++) begin
      mv[t] = 0;
      mtag[t] = 0;
    end
    exp_done = 0; exp_we = 0; exp_rd = 0;
    exp_res = '0;
  endtask

  // Drive one slot at the falling edge, let the DUT take it at the rising
  // edge, then advance the model and leave the expected outputs for the caller.
  task automatic cycle(input bit v, input bit sc, input bit lr, input bit st,
                       input int tid, input logic [31:0] addr);
    int unsigned g;
    bit succ;
    @(negedge clk);
    bus.i_valid     = v;
    bus.i_sc        = sc;
    bus.i_lr        = lr;
    bus.i_store     = st;
    bus.i_thread_id = 4'(tid);
    bus.i_addr      = addr;
    @(posedge clk);
    #1;
    g = addr >> 2;
    exp_done = 0; exp_we = 0; exp_rd = 0;
    if (v && sc) begin
      succ = mv[tid] && (mtag[tid] == g);
      exp_done = 1;
      exp_we   = succ;
      exp_rd   = !succ;
      if (succ) begin
        for (int t = 0; t < NT; t++)
          if (mv[t] && mtag[t] == g) mv[t] = 0;
      end
      mv[tid] = 0;
    end else if (v && lr) begin
      mv[tid] = 1;
      mtag[tid] = g;
    end else if (v && st) begin
      for (int t = 0; t < NT; t++)
        if (mv[t] && mtag[t] == g) mv[t] = 0;
    end
    exp_res = model_res();
    $display("t=%0t slot v=%0b sc=%0b lr=%0b st=%0b hart=%0d addr=0x%08h -> done=%0b we=%0b rd=%0b res=%04h",
             $time, v, sc, lr, st, tid, addr, bus.o_sc_done, bus.o_sc_mem_we,
             bus.o_sc_rd_val, bus.o_res_valid);
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_verdict got=%03b want=000",
               {bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val});
    end
    n_cmp++;
    if (bus.o_res_valid !== '0) begin
      n_bad++;
      $display("FAIL reset_res got=%04h want=0000", bus.o_res_valid);
    end
  endtask

  task automatic test_sc_no_lr();
    cycle(1, 1, 0, 0, 3, 32'h100);
    n_cmp++;
    if ({bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val} !== 3'b101) begin
      n_bad++;
      $display("FAIL sc_no_lr got=%03b want=101",
               {bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val});
    end
    n_cmp++;
    if (bus.o_res_valid !== '0) begin
      n_bad++;
      $display("FAIL sc_no_lr_res got=%04h want=0000", bus.o_res_valid);
    end
    cycle(0, 0, 0, 0, 0, 32'h0);
    n_cmp++;
    if ({bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val} !== 3'b000) begin
      n_bad++;
      $display("FAIL pulse_end got=%03b want=000",
               {bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val});
    end
  endtask

  task automatic test_lr_sc_basic();
    cycle(1, 0, 1, 0, 5, 32'h2000);
    n_cmp++;
    if (bus.o_res_valid[5] !== 1'b1) begin
      n_bad++;
      $display("FAIL lr_sets got=%0b want=1", bus.o_res_valid[5]);
    end
    cycle(1, 1, 0, 0, 5, 32'h2000);
    n_cmp++;
    if ({bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val} !== 3'b110) begin
      n_bad++;
      $display("FAIL sc_success got=%03b want=110",
               {bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val});
    end
    n_cmp++;
    if (bus.o_res_valid[5] !== 1'b0) begin
      n_bad++;
      $display("FAIL sc_clears_own got=%0b want=0", bus.o_res_valid[5]);
    end
    cycle(1, 1, 0, 0, 5, 32'h2000);
    n_cmp++;
    if ({bus.o_sc_mem_we, bus.o_sc_rd_val} !== 2'b01) begin
      n_bad++;
      $display("FAIL sc_repeat got=%02b want=01", {bus.o_sc_mem_we, bus.o_sc_rd_val});
    end
  endtask

  task automatic test_other_hart_clear();
    cycle(1, 0, 1, 0, 1, 32'h40);
    cycle(1, 0, 1, 0, 2, 32'h40);
    cycle(1, 1, 0, 0, 1, 32'h42);
    n_cmp++;
    if ({bus.o_sc_mem_we, bus.o_sc_rd_val} !== 2'b10) begin
      n_bad++;
      $display("FAIL sc_granule_match got=%02b want=10", {bus.o_sc_mem_we, bus.o_sc_rd_val});
    end
    n_cmp++;
    if (bus.o_res_valid[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL peer_cleared got=%0b want=0", bus.o_res_valid[2]);
    end
    cycle(1, 1, 0, 0, 2, 32'h40);
    n_cmp++;
    if ({bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val} !== 3'b101) begin
      n_bad++;
      $display("FAIL peer_sc_next got=%03b want=101",
               {bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val});
    end
  endtask

  task automatic test_store_clear();
    cycle(1, 0, 1, 0, 7, 32'h80);
    cycle(1, 0, 0, 1, 0, 32'h83);
    n_cmp++;
    if ({bus.o_sc_done, bus.o_res_valid[7]} !== 2'b00) begin
      n_bad++;
      $display("FAIL store_hit got=%02b want=00", {bus.o_sc_done, bus.o_res_valid[7]});
    end
    cycle(1, 1, 0, 0, 7, 32'h80);
    n_cmp++;
    if (bus.o_sc_rd_val !== 1'b1) begin
      n_bad++;
      $display("FAIL sc_after_store got=%0b want=1", bus.o_sc_rd_val);
    end
    cycle(1, 0, 1, 0, 7, 32'h80);
    cycle(1, 0, 0, 1, 0, 32'h84);
    cycle(1, 1, 0, 0, 7, 32'h80);
    n_cmp++;
    if ({bus.o_sc_mem_we, bus.o_sc_rd_val} !== 2'b10) begin
      n_bad++;
      $display("FAIL sc_after_store_miss got=%02b want=10", {bus.o_sc_mem_we, bus.o_sc_rd_val});
    end
  endtask

  task automatic test_lr_overwrite();
    cycle(1, 0, 1, 0, 4, 32'h10);
    cycle(1, 0, 1, 0, 4, 32'h20);
    cycle(1, 1, 0, 0, 4, 32'h10);
    n_cmp++;
    if ({bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val, bus.o_res_valid[4]} !== 4'b1010) begin
      n_bad++;
      $display("FAIL lr_overwrite got=%04b want=1010",
               {bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val, bus.o_res_valid[4]});
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, 1, 0, 8, 32'h600);
    cycle(1, 1, 0, 0, 9, 32'h600);
    n_cmp++;
    if ({bus.o_sc_mem_we, bus.o_sc_rd_val, bus.o_res_valid[8]} !== 3'b011) begin
      n_bad++;
      $display("FAIL lr_a_sc_b got=%03b want=011",
               {bus.o_sc_mem_we, bus.o_sc_rd_val, bus.o_res_valid[8]});
    end
    // Priority: SC wins over LR and store in the same slot.
    cycle(1, 1, 1, 1, 8, 32'h600);
    n_cmp++;
    if ({bus.o_sc_done, bus.o_sc_mem_we, bus.o_res_valid[8]} !== 3'b110) begin
      n_bad++;
      $display("FAIL priority_sc got=%03b want=110",
               {bus.o_sc_done, bus.o_sc_mem_we, bus.o_res_valid[8]});
    end
    // Invalid slot is ignored entirely.
    cycle(0, 0, 1, 0, 8, 32'h600);
    n_cmp++;
    if (bus.o_res_valid[8] !== 1'b0) begin
      n_bad++;
      $display("FAIL invalid_ignored got=%0b want=0", bus.o_res_valid[8]);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, 1, 0, 6, 32'h300);
    cycle(1, 1, 0, 0, 6, 32'h300);
    rst_n = 1'b0;
    #1;
    model_clear();
    n_cmp++;
    if ({bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val} !== 3'b000 || bus.o_res_valid !== '0) begin
      n_bad++;
      $display("FAIL reset_mid got=%03b/%04h want=000/0000",
               {bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val}, bus.o_res_valid);
    end
    @(negedge clk);
    bus.i_valid = 0; bus.i_sc = 0; bus.i_lr = 0; bus.i_store = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 0, 1, 0, 9, 32'h300);
    n_cmp++;
    if (bus.o_sc_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle got=%0b want=0", bus.o_sc_done);
    end
    cycle(1, 1, 0, 0, 6, 32'h300);
    n_cmp++;
    if ({bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val} !== 3'b101) begin
      n_bad++;
      $display("FAIL sc_after_reset got=%03b want=101",
               {bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val});
    end
  endtask

  task automatic test_random();
    int kind;
    bit v, sc, lr, st;
    int tid;
    logic [31:0] addr;
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 9));
      v  = ($urandom_range(0, 7) != 0);
      sc = (kind <= 2) || (kind == 9);
      lr = (kind >= 3 && kind <= 6) || (kind == 9 && $urandom_range(0, 1) == 1);
      st = (kind == 7) || (kind == 9 && $urandom_range(0, 1) == 1);
      tid = int'($urandom_range(0, NT - 1));
      addr = 32'h1000 + 32'($urandom_range(0, 3)) * 4 + 32'($urandom_range(0, 3));
      cycle(v, sc, lr, st, tid, addr);
      n_cmp++;
      if ({bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val} !== {exp_done, exp_we, exp_rd}) begin
        n_bad++;
        $display("FAIL rand_verdict[%0d] got=%03b want=%03b", i,
                 {bus.o_sc_done, bus.o_sc_mem_we, bus.o_sc_rd_val}, {exp_done, exp_we, exp_rd});
      end
      n_cmp++;
      if (bus.o_res_valid !== exp_res) begin
        n_bad++;
        $display("FAIL rand_res[%0d] got=%04h want=%04h", i, bus.o_res_valid, exp_res);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_valid = 0; bus.i_sc = 0; bus.i_lr = 0; bus.i_store = 0;
    bus.i_thread_id = '0; bus.i_addr = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_sc_no_lr();
    test_lr_sc_basic();
    test_other_hart_clear();
    test_store_clear();
    test_lr_overwrite();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
